// File: rtl/irq_scheduler.sv
// irq_scheduler: edge-triggered interrupt scheduler with a four-state
// issue/service handshake, acceptance timeout and enable mask.
// Optional macro IRQ_SCHEDULER_RR_EN: round-robin arbitration instead of
// fixed priority (highest index wins).
module irq_scheduler #(
   parameter int NSRC   = 7,
   parameter int ACK_TO = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src_req,
   input  logic            mask_wr,
   input  logic [NSRC-1:0] mask_data,
   input  logic            inter,
   input  logic            eirq,
   output logic            irq1,
   output logic            irq2,
   output logic            irq3,
   output logic [NSRC-1:0] pending,
   output logic            busy,
   output logic            to_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, SERVICE, GAP} state_t;

   state_t          state, state_d;
   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] cand;
   logic [NSRC-1:0] edge_det;
   logic [NSRC-1:0] clr;
   logic [3:0]      cnt, cnt_d;
   logic [2:0]      sel_q, sel_d;
   logic [2:0]      win;
   logic            to_err_d;
   logic            serve;
   logic [2:0]      code;

   assign cand     = pending & mask;
   assign edge_det = src_req & ~src_q;

`ifdef IRQ_SCHEDULER_RR_EN
   logic [2:0] last_q;

   // Round-robin pick: scan from last-served-1 downward with wrap; the
   // candidate nearest that start is assigned last and therefore wins.
   always_comb begin
      win = '0;
      for (int k = NSRC; k >= 1; k--) begin
         for (int i = 0; i < NSRC; i++) begin
            if (i == (int'(last_q) + NSRC - k) % NSRC && cand[i])
               win = 3'(i);
         end
      end
   end

   // Remember the source that was actually accepted by the CPU.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       last_q <= 3'(NSRC - 1);
      else if (serve) last_q <= sel_q;
   end
`else
   // Fixed priority: highest pending-and-enabled index wins.
   always_comb begin
      win = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (cand[i]) win = 3'(i);
      end
   end
`endif

   // Served-bit clear mask; a coinciding new edge still sets the bit.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NSRC; i++) begin
         clr[i] = serve && (sel_q == 3'(i));
      end
   end

   // Next-state logic, timeout counting and index latching.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      sel_d    = sel_q;
      to_err_d = 1'b0;
      serve    = 1'b0;
      case (state)
         IDLE: begin
            if (|cand && !inter) begin
               state_d = ISSUE;
               sel_d   = win;
               cnt_d   = '0;
            end
         end
         ISSUE: begin
            if (inter) begin
               state_d = SERVICE;
               serve   = 1'b1;
            end else if (cnt == 4'(ACK_TO - 1)) begin
               state_d  = IDLE;
               to_err_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt + 4'd1;
            end
         end
         SERVICE: begin
            if (eirq) state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, counters, sample/pending/mask registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         src_q   <= '0;
         pending <= '0;
         mask    <= '1;
         cnt     <= '0;
         sel_q   <= '0;
         to_err  <= 1'b0;
      end else begin
         state   <= state_d;
         src_q   <= src_req;
         pending <= (pending & ~clr) | edge_det;
         if (mask_wr) mask <= mask_data;
         cnt     <= cnt_d;
         sel_q   <= sel_d;
         to_err  <= to_err_d;
      end
   end

   // Code is visible only while the interrupt is being offered.
   assign code = (state == ISSUE) ? sel_q + 3'd1 : 3'd0;
   assign {irq3, irq2, irq1} = code;
   assign busy = (state != IDLE);

endmodule
